// File: rtl/ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keycode_decoder
// Purpose  : PS/2 device-to-host receiver. It conditions the raw clock and
//            data pins, frames 11-bit packets, strips the F0 (break) and E0
//            (extended) prefixes, and presents keycode/press/extended with a
//            code_valid strobe.
// Options  : PS2_PARITY_CHECK_EN - when defined, odd parity is enforced and
//            a byte that fails the check is reported on parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keycode_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       press,
  output logic       extended,
  output logic       code_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int c_FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                r_clk_s1, r_clk_s2;
  logic                r_data_s1, r_data_s2;
  logic                r_clk_filt;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                w_filt_flip;
  logic                w_fe;

  state_t              r_state;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_shift;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                r_byte_rdy;
  logic                r_frame_err;
  logic                r_brk_pend;
  logic                r_ext_pend;
`ifdef PS2_PARITY_CHECK_EN
  logic                r_parity_bit;
  logic                r_parity_err;
`endif

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1 to avoid a false edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // The filtered clock flips once FILTER_LEN consecutive samples disagree with it
  assign w_filt_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == c_FILT_LAST);
  assign w_fe        = w_filt_flip && r_clk_filt;

  // Glitch filter on the synchronized PS/2 clock
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Frame FSM: advances on filtered falling edges, abandons a stalled frame on timeout.
  // A falling edge takes priority over the timeout in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_to_cnt     <= '0;
      r_byte_rdy   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity_bit <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
      if (w_fe) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            // A high start bit is line noise, not a frame
            if (!r_data_s2) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shift  <= {r_data_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity_bit <= r_data_s2;
`endif
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!r_data_s2) r_frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            else if (!(r_parity_bit ^ (^r_shift))) r_parity_err <= 1'b1;
`endif
            else r_byte_rdy <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_TO_LAST) begin
        r_to_cnt    <= '0;
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Byte decoder: prefixes set pending flags, any other byte publishes a key event
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode    <= '0;
      press      <= 1'b0;
      extended   <= 1'b0;
      code_valid <= 1'b0;
      r_brk_pend <= 1'b0;
      r_ext_pend <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (r_byte_rdy) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          keycode    <= r_shift;
          press      <= ~r_brk_pend;
          extended   <= r_ext_pend;
          code_valid <= 1'b1;
          r_brk_pend <= 1'b0;
          r_ext_pend <= 1'b0;
        end
      end
    end
  end

  assign frame_err = r_frame_err;
`ifdef PS2_PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keycode_decoder
// Purpose  : Self-checking bench for ps2_keycode_decoder. Drives PS/2 frames
//            from a table of directed vectors, plus hand-written sequences for
//            timeout, glitch rejection, mid-frame reset and decode latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_decoder;

  localparam int c_FILTER  = 8;
  localparam int c_TIMEOUT = 400;
  localparam int c_HALF    = 20;   // PS/2 half period in Clk cycles

  logic       Clk;
  logic       Reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       press;
  logic       extended;
  logic       code_valid;
  logic       frame_err;
  logic       parity_err;

  ps2_keycode_decoder #(
    .FILTER_LEN    (c_FILTER),
    .TIMEOUT_CYCLES(c_TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .press     (press),
    .extended  (extended),
    .code_valid(code_valid),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int cv_cnt = 0, fe_cnt = 0, pe_cnt = 0, excl_cnt = 0;
  int last_cv_cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge of Clk
  always @(negedge Clk) begin
    if (code_valid === 1'b1) begin
      cv_cnt = cv_cnt + 1;
      last_cv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (code_valid === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1)) excl_cnt = excl_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         exp_cv;
    logic [7:0] exp_kc;
    logic       exp_press;
    logic       exp_ext;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(input logic [7:0] d, input logic bp, input logic bs,
                               input int cv, input logic [7:0] kc, input logic p,
                               input logic e, input int fe, input int pe);
    vec_t v;
    v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_cv = cv; v.exp_kc = kc;
    v.exp_press = p; v.exp_ext = e; v.exp_fe = fe; v.exp_pe = pe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // One PS/2 bit: data changes while the clock is high, then the clock falls
  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_clk(5);
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(c_HALF - 8);
    end else begin
      wait_clk(c_HALF);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_clk(c_HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic bad_stop, input logic glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit(bad_par ? ~odd_par(d) : odd_par(d), glitch);
    ps2_bit(bad_stop ? 1'b0 : 1'b1, glitch);
    ps2_data = 1'b1;
    wait_clk(60);
  endtask

  int s_cv, s_fe, s_pe, lat;

  initial begin
    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    check("in_reset_keycode", {24'd0, keycode}, 32'h0);
    check("in_reset_code_valid", {31'd0, code_valid}, 32'h0);
    wait_clk(2);
    Reset_n = 1'b1;
    wait_clk(30);

    // Idle after reset
    check("rst_keycode",    {24'd0, keycode},    32'h0);
    check("rst_press",      {31'd0, press},      32'h0);
    check("rst_extended",   {31'd0, extended},   32'h0);
    check("rst_code_valid", {31'd0, code_valid}, 32'h0);
    check("rst_frame_err",  {31'd0, frame_err},  32'h0);
    check("rst_parity_err", {31'd0, parity_err}, 32'h0);
    check("rst_pulse_cnt",  cv_cnt + fe_cnt + pe_cnt, 32'h0);

    vecs[0]  = mkv(8'h1D, 1'b0, 1'b0, 1, 8'h1D, 1'b1, 1'b0, 0, 0);
    vecs[1]  = mkv(8'hF0, 1'b0, 1'b0, 0, 8'h1D, 1'b1, 1'b0, 0, 0);
    vecs[2]  = mkv(8'h1D, 1'b0, 1'b0, 1, 8'h1D, 1'b0, 1'b0, 0, 0);
    vecs[3]  = mkv(8'h23, 1'b0, 1'b0, 1, 8'h23, 1'b1, 1'b0, 0, 0);
    vecs[4]  = mkv(8'hE0, 1'b0, 1'b0, 0, 8'h23, 1'b1, 1'b0, 0, 0);
    vecs[5]  = mkv(8'hF0, 1'b0, 1'b0, 0, 8'h23, 1'b1, 1'b0, 0, 0);
    vecs[6]  = mkv(8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b0, 1'b1, 0, 0);
    vecs[7]  = mkv(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b1, 1'b0, 0, 0);
    vecs[8]  = mkv(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b1, 1'b0, 0, 0);
    vecs[9]  = mkv(8'h55, 1'b0, 1'b1, 0, 8'h1C, 1'b1, 1'b0, 1, 0);
    vecs[10] = mkv(8'hE0, 1'b0, 1'b0, 0, 8'h1C, 1'b1, 1'b0, 0, 0);
    vecs[11] = mkv(8'h6B, 1'b0, 1'b1, 0, 8'h1C, 1'b1, 1'b0, 1, 0);
    vecs[12] = mkv(8'h6B, 1'b0, 1'b0, 1, 8'h6B, 1'b1, 1'b1, 0, 0);
`ifdef PS2_PARITY_CHECK_EN
    vecs[13] = mkv(8'h1B, 1'b1, 1'b0, 0, 8'h6B, 1'b1, 1'b1, 0, 1);
`else
    vecs[13] = mkv(8'h1B, 1'b1, 1'b0, 1, 8'h1B, 1'b1, 1'b0, 0, 0);
`endif
    vecs[14] = mkv(8'h4B, 1'b0, 1'b0, 1, 8'h4B, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      s_cv = cv_cnt; s_fe = fe_cnt; s_pe = pe_cnt;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0);
      check($sformatf("v%0d_cv_pulses", i), cv_cnt - s_cv, vecs[i].exp_cv);
      check($sformatf("v%0d_keycode", i), {24'd0, keycode}, {24'd0, vecs[i].exp_kc});
      check($sformatf("v%0d_press", i), {31'd0, press}, {31'd0, vecs[i].exp_press});
      check($sformatf("v%0d_extended", i), {31'd0, extended}, {31'd0, vecs[i].exp_ext});
      check($sformatf("v%0d_frame_err", i), fe_cnt - s_fe, vecs[i].exp_fe);
      check($sformatf("v%0d_parity_err", i), pe_cnt - s_pe, vecs[i].exp_pe);
    end

    // Decode latency of the last frame: about 2 sync + FILTER_LEN filter + 2 pipeline cycles
    lat = last_cv_cyc - last_fall_cyc;
    check("latency_window", {31'd0, (lat >= 9 && lat <= 13)}, 32'h1);

    // Five clock edges then silence: timeout must abandon the frame
    s_cv = cv_cnt; s_fe = fe_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_clk(200);
    check("timeout_not_early", fe_cnt - s_fe, 32'd0);
    wait_clk(300);
    check("timeout_frame_err", fe_cnt - s_fe, 32'd1);
    check("timeout_no_cv", cv_cnt - s_cv, 32'd0);
    check("timeout_kc_held", {24'd0, keycode}, 32'h4B);
    s_cv = cv_cnt;
    send_frame(8'h44, 1'b0, 1'b0, 1'b0);
    check("after_to_cv", cv_cnt - s_cv, 32'd1);
    check("after_to_kc", {24'd0, keycode}, 32'h44);
    check("after_to_press", {31'd0, press}, 32'h1);

    // A 3-cycle low glitch with data low must not start a frame
    s_fe = fe_cnt; s_cv = cv_cnt;
    ps2_data = 1'b0;
    wait_clk(4);
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(4);
    ps2_data = 1'b1;
    wait_clk(c_TIMEOUT + 100);
    check("idle_glitch_no_err", fe_cnt - s_fe, 32'd0);
    check("idle_glitch_no_cv", cv_cnt - s_cv, 32'd0);

    // Glitches inside every high phase of a frame
    s_cv = cv_cnt; s_fe = fe_cnt;
    send_frame(8'h2C, 1'b0, 1'b0, 1'b1);
    check("glitch_frame_cv", cv_cnt - s_cv, 32'd1);
    check("glitch_frame_kc", {24'd0, keycode}, 32'h2C);
    check("glitch_frame_err", fe_cnt - s_fe, 32'd0);

    // Break prefix pending, then reset mid-frame clears everything
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    Reset_n = 1'b0;
    wait_clk(3);
    check("midrst_keycode",  {24'd0, keycode},  32'h0);
    check("midrst_press",    {31'd0, press},    32'h0);
    check("midrst_extended", {31'd0, extended}, 32'h0);
    Reset_n = 1'b1;
    wait_clk(20);
    s_cv = cv_cnt; s_fe = fe_cnt;
    send_frame(8'h2B, 1'b0, 1'b0, 1'b0);
    check("postrst_cv", cv_cnt - s_cv, 32'd1);
    check("postrst_kc", {24'd0, keycode}, 32'h2B);
    check("postrst_press", {31'd0, press}, 32'h1);
    check("postrst_ext", {31'd0, extended}, 32'h0);
    check("postrst_no_err", fe_cnt - s_fe, 32'd0);

    check("cv_err_exclusive", excl_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
